// File: rtl/apu_pkg.sv
// Shared audio-path definitions: sample/frame widths and the stereo frame type.
package apu_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;

    // Left sample occupies the upper half so bit FRAME_BITS-1 is the first bit on the wire
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_frame_t;

    // Word select for a given bit slot: high for slots 15..30 so it leads each MSB by one bclk
    function automatic logic lrclk_for_bit(input logic [4:0] f);
        return (f >= 5'd15) && (f <= 5'd30);
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Upstream stereo-frame stream into the I2S transmitter (valid/ready handshake).
interface i2s_tx_if;
    import apu_pkg::*;

    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/i2s_tx_fifo.sv
// Small synchronous frame buffer between the upstream stream and the serialiser.
module sample_fifo
    import apu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  stereo_frame_t          wdata,
    input  logic                   pop,
    output stereo_frame_t          rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    stereo_frame_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only the pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers stereo frames and serialises them MSB first, left channel on lrclk=0.
module i2s_tx
    import apu_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk_25mhz,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        mute,
    i2s_tx_if.slave                     s,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    output logic                        audio_bclk,
    output logic                        audio_lrclk,
    output logic                        audio_din,
    output logic                        audio_sclk,
    output logic                        audio_xsmt
);

    logic [7:0]            div;
    logic                  div_tc;
    logic                  fall_event;
    logic                  frame_wrap;
    logic [4:0]            bit_cnt;
    logic [4:0]            bit_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] next_bits;

    stereo_frame_t         push_frame;
    stereo_frame_t         fifo_rdata;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign push_frame.left  = s.s_left;
    assign push_frame.right = s.s_right;
    assign s.s_ready        = !fifo_full;
    assign fifo_push        = s.s_valid && s.s_ready;

    assign div_tc     = (div == 8'(BCLK_HALF_DIV - 1));
    assign fall_event = enable && div_tc && audio_bclk;
    assign frame_wrap = fall_event && (bit_cnt == 5'd31);
    assign fifo_pop   = frame_wrap && !fifo_empty;
    assign bit_next   = bit_cnt + 5'd1;
    assign next_bits  = fifo_empty ? '0 : fifo_rdata;

    assign audio_sclk = 1'b0;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_25mhz),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_frame),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bit-clock divider: bclk toggles at terminal count, parked low while disabled
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            audio_bclk <= 1'b0;
        end else if (!enable) begin
            div        <= '0;
            audio_bclk <= 1'b0;
        end else if (div_tc) begin
            div        <= '0;
            audio_bclk <= !audio_bclk;
        end else begin
            div        <= div + 8'd1;
        end
    end

    // Serialiser: lrclk/din change only on bclk falls; a frame is loaded (or zero-filled) at slot 0
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 5'd31;
            shift_reg   <= '0;
            audio_lrclk <= 1'b0;
            audio_din   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= frame_wrap && fifo_empty;
            if (!enable) begin
                bit_cnt     <= 5'd31;
                audio_lrclk <= 1'b0;
                audio_din   <= 1'b0;
            end else if (fall_event) begin
                bit_cnt     <= bit_next;
                audio_lrclk <= lrclk_for_bit(bit_next);
                if (bit_cnt == 5'd31) begin
                    shift_reg <= next_bits;
                    audio_din <= next_bits[FRAME_BITS-1];
                end else begin
                    audio_din <= shift_reg[~bit_next];
                end
            end
        end
    end

    // Soft-mute pin is active low at the codec, so register the inverse of mute
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            audio_xsmt <= 1'b0;
        end else begin
            audio_xsmt <= !mute;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, a monitor rebuilds frames from the wire.
module tb_i2s_tx;
    import apu_pkg::*;

    logic       clk_25mhz = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       mute;
    logic [2:0] fifo_level;
    logic       underrun;
    logic       audio_bclk;
    logic       audio_lrclk;
    logic       audio_din;
    logic       audio_sclk;
    logic       audio_xsmt;

    i2s_tx_if bus ();

    i2s_tx #(
        .BCLK_HALF_DIV (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .enable      (enable),
        .mute        (mute),
        .s           (bus),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .audio_bclk  (audio_bclk),
        .audio_lrclk (audio_lrclk),
        .audio_din   (audio_din),
        .audio_sclk  (audio_sclk),
        .audio_xsmt  (audio_xsmt)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          urun_cnt = 0;
    logic [31:0] sb [$];

    // 25 MHz system clock
    always #20 clk_25mhz = ~clk_25mhz;

    // Free-running cycle count, read only at negedges
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // Overall time limit
    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one frame; exp_accept says whether the bench expects the FIFO to take it
    task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r, input bit exp_accept);
        @(negedge clk_25mhz);
        bus.s_valid = 1'b1;
        bus.s_left  = l;
        bus.s_right = r;
        check_output("s_ready_on_push", {31'd0, bus.s_ready}, {31'd0, exp_accept});
        if (exp_accept) sb.push_back({l, r});
        @(posedge clk_25mhz);
    endtask

    task automatic wait_edge(input bit use_lr, input bit rising, input int budget, output int when);
        logic prev;
        logic cur;
        prev = use_lr ? audio_lrclk : audio_bclk;
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_25mhz);
            cur = use_lr ? audio_lrclk : audio_bclk;
            if (cur == rising && prev != rising) begin
                when = cyc;
                return;
            end
            prev = cur;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_edge timeout: lr=%0d rising=%0d after %0d cycles", use_lr, rising, budget);
    endtask

    // Monitor: shift din on every bclk rise; the slot-31 rise (lrclk 1->0) closes a frame
    logic        mon_prev_bclk = 1'b0;
    logic        mon_prev_lr   = 1'b0;
    logic        mon_urflag    = 1'b0;
    logic [31:0] mon_shift     = '0;
    int          mon_bits      = 0;

    always @(negedge clk_25mhz) begin
        if (underrun === 1'b1) urun_cnt++;
        if (!rst_n || !enable) begin
            mon_bits      = 0;
            mon_urflag    = 1'b0;
            mon_prev_lr   = 1'b0;
            mon_prev_bclk = 1'b0;
        end else begin
            if (underrun === 1'b1) mon_urflag = 1'b1;
            if (!mon_prev_bclk && audio_bclk) begin
                mon_shift = {mon_shift[30:0], audio_din};
                mon_bits++;
                if (mon_prev_lr && !audio_lrclk && mon_bits >= 32) begin
                    if (mon_urflag) begin
                        check_output("underrun_frame", mon_shift, 32'h0);
                    end else if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_frame: got 0x%0h with nothing expected", mon_shift);
                    end else begin
                        check_output("frame", mon_shift, sb.pop_front());
                    end
                    mon_urflag = 1'b0;
                end
                mon_prev_lr = audio_lrclk;
            end
            mon_prev_bclk = audio_bclk;
        end
    end

    initial begin
        int t0, r1, f1, r2, l1, l2, l3, u0;

        rst_n       = 1'b0;
        enable      = 1'b0;
        mute        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;

        // Reset values
        repeat (3) @(negedge clk_25mhz);
        check_output("rst_s_ready",    {31'd0, bus.s_ready}, 32'd1);
        check_output("rst_fifo_level", {29'd0, fifo_level},  32'd0);
        check_output("rst_underrun",   {31'd0, underrun},    32'd0);
        check_output("rst_bclk",       {31'd0, audio_bclk},  32'd0);
        check_output("rst_lrclk",      {31'd0, audio_lrclk}, 32'd0);
        check_output("rst_din",        {31'd0, audio_din},   32'd0);
        check_output("rst_xsmt",       {31'd0, audio_xsmt},  32'd0);
        check_output("sclk_zero",      {31'd0, audio_sclk},  32'd0);
        rst_n = 1'b1;

        // Mute: xsmt follows ~mute one cycle later
        @(negedge clk_25mhz);
        check_output("xsmt_unmuted", {31'd0, audio_xsmt}, 32'd1);
        mute = 1'b1;
        check_output("xsmt_hold", {31'd0, audio_xsmt}, 32'd1);
        @(posedge clk_25mhz); #1;
        check_output("xsmt_muted", {31'd0, audio_xsmt}, 32'd0);
        @(negedge clk_25mhz);
        mute = 1'b0;
        @(posedge clk_25mhz); #1;
        check_output("xsmt_release", {31'd0, audio_xsmt}, 32'd1);

        // Serialisation and timing: L=0x8001 R=0x7FFE
        apply_stimulus(16'h8001, 16'h7FFE, 1'b1);
        @(negedge clk_25mhz);
        bus.s_valid = 1'b0;
        check_output("level_one", {29'd0, fifo_level}, 32'd1);
        enable = 1'b1;
        t0 = cyc;
        wait_edge(1'b0, 1'b1, 64, r1);
        check_output("first_bclk_rise", 32'(r1 - t0), 32'd8);
        wait_edge(1'b0, 1'b0, 64, f1);
        check_output("first_fall_event", 32'(f1 - t0), 32'd16);
        check_output("bclk_high", 32'(f1 - r1), 32'd8);
        wait_edge(1'b0, 1'b1, 64, r2);
        check_output("bclk_period", 32'(r2 - r1), 32'd16);
        wait_edge(1'b1, 1'b1, 600, l1);
        check_output("lrclk_first_rise", 32'(l1 - t0), 32'd256);
        wait_edge(1'b1, 1'b0, 600, l2);
        check_output("lrclk_high", 32'(l2 - l1), 32'd256);
        wait_edge(1'b1, 1'b1, 600, l3);
        check_output("lrclk_period", 32'(l3 - l1), 32'd512);

        // Underrun: no data, one pulse per 512 cycles
        u0 = urun_cnt;
        repeat (1536) @(negedge clk_25mhz);
        check_output("underrun_count", 32'(urun_cnt - u0), 32'd3);

        // Full: disable mid-frame, push five frames, only four fit
        @(negedge clk_25mhz);
        enable = 1'b0;
        @(negedge clk_25mhz);
        check_output("idle_bclk",  {31'd0, audio_bclk},  32'd0);
        check_output("idle_lrclk", {31'd0, audio_lrclk}, 32'd0);
        check_output("idle_din",   {31'd0, audio_din},   32'd0);
        apply_stimulus(16'h1234, 16'h5678, 1'b1);
        apply_stimulus(16'h9ABC, 16'hDEF0, 1'b1);
        apply_stimulus(16'h0F0F, 16'hF0F0, 1'b1);
        apply_stimulus(16'hAAAA, 16'h5555, 1'b1);
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk_25mhz);
        bus.s_valid = 1'b0;
        check_output("full_level", {29'd0, fifo_level},  32'd4);
        check_output("full_ready", {31'd0, bus.s_ready}, 32'd0);
        mute   = 1'b1;
        enable = 1'b1;
        repeat (5 * 512 + 64) @(negedge clk_25mhz);
        check_output("xsmt_during_play", {31'd0, audio_xsmt}, 32'd0);
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        mute = 1'b0;

        // Reset mid-frame at slot 20 with one more frame still buffered
        enable = 1'b0;
        apply_stimulus(16'hCAFE, 16'hBEEF, 1'b1);
        apply_stimulus(16'h0001, 16'h8000, 1'b1);
        @(negedge clk_25mhz);
        bus.s_valid = 1'b0;
        enable = 1'b1;
        wait_edge(1'b1, 1'b1, 600, l1);
        for (int i = 0; i < 5; i++) wait_edge(1'b0, 1'b0, 40, f1);
        repeat (10) @(negedge clk_25mhz);
        check_output("pre_rst_lrclk", {31'd0, audio_lrclk}, 32'd1);
        check_output("pre_rst_bclk",  {31'd0, audio_bclk},  32'd1);
        check_output("pre_rst_level", {29'd0, fifo_level},  32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_bclk",  {31'd0, audio_bclk},  32'd0);
        check_output("midrst_lrclk", {31'd0, audio_lrclk}, 32'd0);
        check_output("midrst_din",   {31'd0, audio_din},   32'd0);
        check_output("midrst_xsmt",  {31'd0, audio_xsmt},  32'd0);
        check_output("midrst_level", {29'd0, fifo_level},  32'd0);
        check_output("midrst_ready", {31'd0, bus.s_ready}, 32'd1);
        sb.delete();
        repeat (3) @(negedge clk_25mhz);
        rst_n = 1'b1;
        check_output("post_rst_level", {29'd0, fifo_level}, 32'd0);
        u0 = urun_cnt;
        repeat (700) @(negedge clk_25mhz);
        check_output("post_rst_underruns", 32'(urun_cnt - u0), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF_DIV, default 8, clk_25mhz cycles per bclk half-period (range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, stereo frames buffered (power of two).
REQ-003 SHALL have port clk_25mhz  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  in  1  1 = run the serial interface; 0 = hold it idle.
REQ-006 SHALL have port mute  in  1  1 = assert codec soft mute.
REQ-007 SHALL have port s_valid  in  1  upstream frame valid.
REQ-008 SHALL have port s_ready  out  1  frame accepted when s_valid & s_ready.
REQ-009 SHALL have port s_left  in  16  left sample, two's complement.
REQ-010 SHALL have port s_right  in  16  right sample, two's complement.
REQ-011 SHALL have port fifo_level  out  3  frames currently buffered (0..FIFO_DEPTH).
REQ-012 SHALL have port underrun  out  1  one-cycle pulse per frame sent without data.
REQ-013 SHALL have port audio_bclk, audio_lrclk, audio_din  out  1 each  I2S bit clock, word select, data.
REQ-014 SHALL have port audio_sclk  out  1  constant 0 (codec derives its own system clock).
REQ-015 SHALL have port audio_xsmt  out  1  registered ~mute.

Function
REQ-016 SHALL count a divider 0..BCLK_HALF_DIV-1 while enable=1; audio_bclk toggles at terminal count; "fall event" = cycle where bclk toggles 1->0.
REQ-017 SHALL keep a 5-bit bit counter f, advanced only on fall events, wrapping 31->0.
REQ-018 SHALL update audio_lrclk and audio_din only on fall events, so both are stable across every bclk rising edge.
REQ-019 SHALL drive audio_lrclk=0 for f in {31,0..14} and 1 for f in 15..30 (word select leads MSB by one bclk, I2S format, left = low).
REQ-020 SHALL drive audio_din = left[15-f] for f 0..15 and right[31-f] for f 16..31, MSB first.
REQ-021 SHALL pop one frame from the FIFO into a 32-bit shift register on the fall event where f wraps 31->0; its MSB appears on audio_din that same event.
REQ-022 SHALL, if the FIFO is empty at that pop point, load all-zero samples and pulse underrun for exactly one clk_25mhz cycle.
REQ-023 SHALL drive s_ready = (fifo_level != FIFO_DEPTH); a push in the same cycle as a pop when full is not accepted (no bypass).
REQ-024 SHALL apply simultaneous push and pop with fifo_level unchanged and both data orderings preserved (FIFO order).
REQ-025 SHALL, when enable=0: hold audio_bclk=0, audio_lrclk=0, audio_din=0, divider=0, f=31, FIFO contents retained and pushes still accepted.
REQ-026 SHALL, on enable 0->1, produce the first fall event after 2*BCLK_HALF_DIV cycles, popping a frame at that event.
REQ-027 SHALL make enable dropping mid-frame abandon the current frame (no re-send on re-enable).
REQ-028 SHALL pass mute only to audio_xsmt (data path unaffected); one-cycle register latency.

Reset
REQ-029 SHALL on rst_n=0 set: FIFO empty, fifo_level=0, s_ready=1, underrun=0, audio_bclk=0, audio_lrclk=0, audio_din=0, audio_xsmt=0, divider=0, f=31, shift register=0.
REQ-030 SHALL take reset asynchronously and release it synchronously to clk_25mhz; reset mid-frame discards buffered and in-flight data.

Structure
REQ-031 SHALL place SAMPLE_W=16, FRAME_BITS=32 and the stereo-frame packed type in the shared apu_pkg package.
REQ-032 SHALL implement the buffer as sub-module sample_fifo (synchronous, FIFO_DEPTH entries of 32 bits, push/pop/level).

Verification
REQ-033 SHALL check timing: enable=1, BCLK_HALF_DIV=8 -> bclk period 16 cycles, lrclk period 512 cycles, 50% duty.
REQ-034 SHALL check serialisation: push L=0x8001, R=0x7FFE -> din reads 1000000000000001 while lrclk=0, then 0111111111111110 while lrclk=1, sampled on bclk rising edges.
REQ-035 SHALL check underrun: no pushes, enable=1 -> din=0 all frames, one underrun pulse per 512 cycles.
REQ-036 SHALL check full: push 5 frames back-to-back with enable=0 -> s_ready=0 after 4th, fifo_level=4, 5th not accepted; after enable the 4 frames emerge in order.
REQ-037 SHALL check reset mid-frame: assert rst_n=0 at f=20 -> all outputs reach reset values immediately; FIFO empty after release.
REQ-038 SHALL check mute: toggle mute -> audio_xsmt follows inverted one cycle later; din unchanged.
